// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: direct-mapped read-only instruction cache with 16-byte lines, miss fill FSM and hit/miss counters
module icache_direct_mapped #(
  parameter int INDEX_BITS = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          read,
  input  logic [31:0]   address,
  output logic [31:0]   readdata,
  output logic          busywait,
  output logic          mem_read,
  output logic [27:0]   mem_address,
  input  logic [127:0]  mem_readdata,
  input  logic          mem_busywait,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
);
  localparam int TW = 28 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;
  state_t state_q, state_d;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0] tag_q [LINES];
  logic [127:0] data_q [LINES];
  logic [27:0] miss_q, miss_d;
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  logic [INDEX_BITS-1:0] idx, fill_idx;
  logic [TW-1:0] tag;
  logic [127:0] line;
  logic hit, fill, unused_ok;
  assign idx = address[3+INDEX_BITS:4];
  assign tag = address[31:4+INDEX_BITS];
  assign line = data_q[idx];
  assign hit = valid_q[idx] && tag_q[idx] == tag;
  assign fill_idx = miss_q[INDEX_BITS-1:0];
  assign fill = state_q == MEM_READ && !mem_busywait;
  assign unused_ok = ^address[1:0];
  assign mem_address = miss_q;
  assign hit_count = hit_count_q;
  assign miss_count = miss_count_q;
  always_comb begin
    state_d = state_q;
    miss_d = miss_q;
    hit_count_d = hit_count_q;
    miss_count_d = miss_count_q;
    readdata = 32'h0;
    busywait = 1'b0;
    mem_read = 1'b0;
    case (state_q)
      IDLE: begin
        readdata = read && hit ? line[{address[3:2], 5'b0} +: 32] : 32'h0;
        busywait = read && !hit;
        hit_count_d = read && hit ? hit_count_q + 32'd1 : hit_count_q;
        if (read && !hit) begin
          miss_d = address[31:4];
          miss_count_d = miss_count_q + 32'd1;
          state_d = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_read = 1'b1;
        busywait = 1'b1;
        state_d = mem_busywait ? MEM_READ : UPDATE;
      end
      default: begin
        busywait = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      miss_q <= 28'h0;
      hit_count_q <= 32'h0;
      miss_count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      miss_q <= miss_d;
      hit_count_q <= hit_count_d;
      miss_count_q <= miss_count_d;
      if (fill) valid_q[fill_idx] <= 1'b1;
    end
  end
  // Line payload needs no reset: valid gates every use of it
  always_ff @(posedge clock) begin
    if (!reset && fill) begin
      data_q[fill_idx] <= mem_readdata;
      tag_q[fill_idx] <= miss_q[27:INDEX_BITS];
    end
  end
endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb_icache_direct_mapped: directed checks of hits, misses, conflicts, fill redirect and reset mid-fill
module tb_icache_direct_mapped;
  logic clock = 1'b0, reset, read;
  logic [31:0] address, readdata, hit_count, miss_count;
  logic busywait, mem_read, mem_busywait;
  logic [27:0] mem_address;
  logic [127:0] mem_readdata;
  int busy_cnt = 0;
  int checks = 0, errors = 0;
  icache_direct_mapped #(.INDEX_BITS(3)) dut (
    .clock(clock), .reset(reset), .read(read), .address(address),
    .readdata(readdata), .busywait(busywait), .mem_read(mem_read),
    .mem_address(mem_address), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait), .hit_count(hit_count), .miss_count(miss_count)
  );
  always #5 clock = ~clock;
  // Memory: word at PC p is ~{p[31:2],2'b00}, busy for exactly one cycle per request
  always_comb begin
    mem_readdata = '0;
    for (int i = 0; i < 4; i++) mem_readdata[32*i +: 32] = ~{mem_address, 2'(i), 2'b00};
  end
  assign mem_busywait = mem_read && busy_cnt < 1;
  always @(posedge clock) busy_cnt <= mem_read ? busy_cnt + 1 : 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic do_miss(input logic [31:0] a, input logic [27:0] ma, input logic [31:0] w);
    read = 1'b1; address = a; #1;
    chk("c0_busy", 32'(busywait), 32'd1);
    chk("c0_memrd", 32'(mem_read), 32'd0);
    cyc(); #1;
    chk("c1_memrd", 32'(mem_read), 32'd1);
    chk("c1_maddr", 32'(mem_address), 32'(ma));
    chk("c1_busy", 32'(busywait), 32'd1);
    cyc(); cyc(); #1;
    chk("c3_busy", 32'(busywait), 32'd1);
    chk("c3_memrd", 32'(mem_read), 32'd0);
    cyc(); #1;
    chk("c4_busy", 32'(busywait), 32'd0);
    chk("c4_data", readdata, w);
  endtask
  initial begin
    reset = 1'b1; read = 1'b0; address = 32'h0;
    cyc(); cyc(); #1;
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_miss", miss_count, 32'd0);
    chk("rst_memrd", 32'(mem_read), 32'd0);
    chk("rst_maddr", 32'(mem_address), 32'd0);
    chk("rst_busy_noread", 32'(busywait), 32'd0);
    read = 1'b1; #1;
    chk("rst_busy_read", 32'(busywait), 32'd1);
    chk("rst_data", readdata, 32'h0);
    reset = 1'b0;
    do_miss(32'h0, 28'h0, 32'hFFFFFFFF);
    chk("miss1_cnt", miss_count, 32'd1);
    cyc(); address = 32'h4; #1;
    chk("hit_w1", readdata, 32'hFFFFFFFB);
    chk("hit_w1_busy", 32'(busywait), 32'd0);
    cyc(); address = 32'h8; #1;
    chk("hit_w2", readdata, 32'hFFFFFFF7);
    cyc(); address = 32'hC; #1;
    chk("hit_w3", readdata, 32'hFFFFFFF3);
    chk("hit_w3_busy", 32'(busywait), 32'd0);
    cyc(); read = 1'b0; address = 32'h40; #1;
    chk("hit_cnt4", hit_count, 32'd4);
    chk("idle_busy", 32'(busywait), 32'd0);
    chk("idle_data", readdata, 32'h0);
    cyc(); #1;
    chk("idle_hits", hit_count, 32'd4);
    chk("idle_miss", miss_count, 32'd1);
    do_miss(32'h80, 28'h8, 32'hFFFFFF7F);
    cyc();
    do_miss(32'h0, 28'h0, 32'hFFFFFFFF);
    chk("conf_miss", miss_count, 32'd3);
    cyc(); read = 1'b1; address = 32'h10; #1;
    chk("rd_c0_busy", 32'(busywait), 32'd1);
    cyc(); address = 32'h20; #1;
    chk("rd_c1_maddr", 32'(mem_address), 32'h1);
    cyc(); #1;
    chk("rd_c2_maddr", 32'(mem_address), 32'h1);
    cyc(); cyc(); #1;
    chk("rd_new_busy", 32'(busywait), 32'd1);
    chk("rd_new_memrd", 32'(mem_read), 32'd0);
    cyc(); #1;
    chk("rd_new_maddr", 32'(mem_address), 32'h2);
    cyc(); cyc(); cyc(); #1;
    chk("rd_0x20_busy", 32'(busywait), 32'd0);
    chk("rd_0x20_data", readdata, 32'hFFFFFFDF);
    cyc(); address = 32'h10; #1;
    chk("rd_0x10_busy", 32'(busywait), 32'd0);
    chk("rd_0x10_data", readdata, 32'hFFFFFFEF);
    chk("rd_miss_cnt", miss_count, 32'd5);
    cyc(); address = 32'h50; cyc(); #1;
    chk("mr_memrd", 32'(mem_read), 32'd1);
    reset = 1'b1;
    cyc(); #1;
    chk("mr_rst_memrd", 32'(mem_read), 32'd0);
    chk("mr_rst_hits", hit_count, 32'd0);
    chk("mr_rst_miss", miss_count, 32'd0);
    chk("mr_rst_maddr", 32'(mem_address), 32'h0);
    reset = 1'b0;
    do_miss(32'h10, 28'h1, 32'hFFFFFFEF);
    cyc(); read = 1'b0; address = 32'h1234; #1;
    chk("end_busy", 32'(busywait), 32'd0);
    chk("end_data", readdata, 32'h0);
    cyc(); #1;
    chk("end_hits", hit_count, 32'd1);
    chk("end_miss", miss_count, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
